// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / flow-control unit.
//   flow_state_e : flow FSM states (RUN, FLUSH)
//   FWD_*        : ALU operand forwarding mux encodings
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } flow_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding select.
// Ports:
//   i_ex_rs, i_ex_rt            : source registers of the EX instruction
//   i_mem_rd, i_mem_reg_write   : destination / write enable in MEM
//   i_wb_rd,  i_wb_reg_write    : destination / write enable in WB
//   o_fwd_a,  o_fwd_b           : mux selects for operand A (rs) / B (rt)
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_ex_rs,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    // MEM holds the younger result, so it wins over WB; $zero is never forwarded.
    function automatic logic [1:0] pick(input logic [REG_AW-1:0] src);
        if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == src))
            return FWD_MEM;
        else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign o_fwd_a = pick(i_ex_rs);
    assign o_fwd_b = pick(i_ex_rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage MIPS pipeline.
// Handles load-use stalls, EX forwarding selects, a multi-cycle IF flush after
// a taken branch/jump, and a mul/div busy interlock.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   id_*                        : sources / class of the instruction in ID
//   ex_*, br_taken              : instruction in EX and its branch resolution
//   mem_*, wb_*                 : destinations / write enables in MEM, WB
//   pc_write, if_id_write       : PC and IF/ID enables (0 = hold)
//   id_ex_bubble                : zero the control fields entering ID/EX
//   if_flush, id_flush          : squash IF / ID instructions
//   fwd_a, fwd_b                : ALU operand forwarding selects
//   md_busy, md_done            : mul/div in progress / finishing this cycle
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_muldiv,
    input  logic              id_uses_hilo,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_flush,
    output logic              id_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_busy,
    output logic              md_done
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("FLUSH_CYCLES must be in 1..7");
    end
    if (MD_LATENCY < 2 || MD_LATENCY > 15) begin : g_bad_md
        $error("MD_LATENCY must be in 2..15");
    end

    flow_state_e r_state, w_state_nxt;
    logic [2:0]  r_flush_cnt, w_flush_cnt_nxt;
    logic [3:0]  r_md_cnt;

    logic        w_load_stall, w_md_stall, w_stall, w_md_issue;
    logic [1:0]  w_fwd_a, w_fwd_b;

    // ---------------- hazard detection ----------------
    assign w_load_stall = (r_state == RUN) && ex_mem_read && (ex_rd != '0) &&
                          ((id_use_rs && (ex_rd == id_rs)) ||
                           (id_use_rt && (ex_rd == id_rt)));
    assign w_md_stall   = (r_md_cnt != 4'd0) && (id_uses_hilo || id_is_muldiv);
    assign w_stall      = w_load_stall || w_md_stall;
    assign w_md_issue   = id_is_muldiv && !w_stall && !br_taken &&
                          (r_state == RUN) && (r_md_cnt == 4'd0);

    // ---------------- flow FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // ---------------- flow FSM: next state ----------------
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        unique case (r_state)
            RUN: begin
                // A single-cycle flush is fully covered by the RUN cycle itself.
                if (br_taken && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                // br_taken is ignored here: the EX instruction is already squashed.
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                if (r_flush_cnt == 3'd1) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // ---------------- flow FSM: outputs ----------------
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (r_state == FLUSH) begin
            if_flush = 1'b1;
        end else if (br_taken) begin
            // Redirect overrides any stall: the stalled instructions are squashed.
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // ---------------- mul/div occupancy ----------------
    // Keeps counting through branch flushes; an issued mul/div always completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_md_cnt <= 4'd0;
        else if (w_md_issue)         r_md_cnt <= 4'(MD_LATENCY);
        else if (r_md_cnt != 4'd0)   r_md_cnt <= r_md_cnt - 4'd1;
    end

    assign md_busy = rst && (r_md_cnt != 4'd0);
    assign md_done = rst && (r_md_cnt == 4'd1);

    // ---------------- forwarding ----------------
    forward_unit #(.REG_AW(REG_AW)) u_fwd (
        .i_ex_rs         (ex_rs),
        .i_ex_rt         (ex_rt),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    assign fwd_a = rst ? w_fwd_a : FWD_RF;
    assign fwd_b = rst ? w_fwd_b : FWD_RF;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test of pipeline_hazard_ctrl with FLUSH_CYCLES=3, MD_LATENCY=4.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, id_is_muldiv, id_uses_hilo;
    logic       ex_mem_read, br_taken, mem_reg_write, wb_reg_write;
    logic       pc_write, if_id_write, id_ex_bubble, if_flush, id_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       md_busy, md_done;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(3), .MD_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_muldiv(id_is_muldiv), .id_uses_hilo(id_uses_hilo),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .br_taken(br_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_flush(if_flush), .id_flush(id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .md_busy(md_busy), .md_done(md_done)
    );

    task automatic clr_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_muldiv = 0; id_uses_hilo = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_mem_read = 0; br_taken = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 0;
        // Conditions that would otherwise forward and branch-flush
        mem_rd = 5'd5; mem_reg_write = 1; ex_rs = 5'd5; br_taken = 1;
        #2;
        nvec++; if (pc_write !== 1'b0) begin nerr++; $display("FAIL rst_pc: got %b want 0", pc_write); end
        nvec++; if (if_id_write !== 1'b0) begin nerr++; $display("FAIL rst_ifid: got %b want 0", if_id_write); end
        nvec++; if (if_flush !== 1'b0 || id_flush !== 1'b0) begin nerr++; $display("FAIL rst_flush: got %b%b want 00", if_flush, id_flush); end
        nvec++; if (fwd_a !== 2'b00) begin nerr++; $display("FAIL rst_fwd: got %b want 00", fwd_a); end
        cyc(); cyc();
        nvec++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin nerr++; $display("FAIL rst_md: got %b%b want 00", md_busy, md_done); end
        clr_inputs();
        rst = 1;
        #1;
        nvec++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin nerr++; $display("FAIL rel_en: got %b%b want 11", pc_write, if_id_write); end
        nvec++; if (id_ex_bubble !== 1'b0 || if_flush !== 1'b0) begin nerr++; $display("FAIL rel_idle: got %b%b want 00", id_ex_bubble, if_flush); end
    endtask

    task automatic test_load_use();
        cyc(); clr_inputs(); set_load_use(); #1;
        nvec++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin nerr++; $display("FAIL ld_en: got %b%b want 00", pc_write, if_id_write); end
        nvec++; if (id_ex_bubble !== 1'b1) begin nerr++; $display("FAIL ld_bub: got %b want 1", id_ex_bubble); end
        // Load moved on: stall must last exactly one cycle
        cyc(); clr_inputs(); #1;
        nvec++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL ld_one: got pc=%b bub=%b want 1 0", pc_write, id_ex_bubble); end
        cyc(); set_load_use(); ex_rd = 0; id_rs = 0; #1;
        nvec++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL ld_r0: got pc=%b bub=%b want 1 0", pc_write, id_ex_bubble); end
        cyc(); clr_inputs(); ex_mem_read = 1; ex_rd = 5'd12; id_rt = 5'd12; id_use_rt = 1; #1;
        nvec++; if (id_ex_bubble !== 1'b1) begin nerr++; $display("FAIL ld_rt: got %b want 1", id_ex_bubble); end
        id_use_rt = 0; #1;
        nvec++; if (id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL ld_nouse: got %b want 0", id_ex_bubble); end
    endtask

    task automatic test_forward();
        cyc(); clr_inputs();
        mem_rd = 5'd5; wb_rd = 5'd5; ex_rs = 5'd5; mem_reg_write = 1; wb_reg_write = 1; ex_rt = 5'd9; #1;
        nvec++; if (fwd_a !== 2'b10) begin nerr++; $display("FAIL fwd_mem: got %b want 10", fwd_a); end
        nvec++; if (fwd_b !== 2'b00) begin nerr++; $display("FAIL fwd_b_none: got %b want 00", fwd_b); end
        mem_reg_write = 0; #1;
        nvec++; if (fwd_a !== 2'b01) begin nerr++; $display("FAIL fwd_wb: got %b want 01", fwd_a); end
        wb_rd = 0; ex_rs = 0; #1;
        nvec++; if (fwd_a !== 2'b00) begin nerr++; $display("FAIL fwd_r0: got %b want 00", fwd_a); end
        mem_reg_write = 1; mem_rd = 5'd9; #1;
        nvec++; if (fwd_b !== 2'b10) begin nerr++; $display("FAIL fwd_b_mem: got %b want 10", fwd_b); end
    endtask

    task automatic test_branch();
        cyc(); clr_inputs(); set_load_use(); br_taken = 1; #1;
        nvec++; if (if_flush !== 1'b1 || id_flush !== 1'b1) begin nerr++; $display("FAIL br_flush: got %b%b want 11", if_flush, id_flush); end
        nvec++; if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL br_nostall: got %b%b%b want 110", pc_write, if_id_write, id_ex_bubble); end
        cyc(); br_taken = 0; #1;
        nvec++; if (if_flush !== 1'b1 || id_flush !== 1'b0 || pc_write !== 1'b1) begin nerr++; $display("FAIL fl1: got if=%b id=%b pc=%b want 1 0 1", if_flush, id_flush, pc_write); end
        cyc(); br_taken = 1; #1;  // ignored while flushing
        nvec++; if (if_flush !== 1'b1 || id_flush !== 1'b0 || id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL fl2: got if=%b id=%b bub=%b want 1 0 0", if_flush, id_flush, id_ex_bubble); end
        cyc(); br_taken = 0; #1;  // back in RUN, load-use now stalls
        nvec++; if (if_flush !== 1'b0 || pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin nerr++; $display("FAIL fl_run: got if=%b pc=%b bub=%b want 0 0 1", if_flush, pc_write, id_ex_bubble); end
    endtask

    task automatic test_muldiv();
        // Issue blocked by a load-use stall
        cyc(); clr_inputs(); set_load_use(); id_is_muldiv = 1;
        cyc(); clr_inputs(); #1;
        nvec++; if (md_busy !== 1'b0) begin nerr++; $display("FAIL md_blk: got %b want 0", md_busy); end
        // cycle 0: issue
        id_is_muldiv = 1; #1;
        nvec++; if (md_busy !== 1'b0 || pc_write !== 1'b1) begin nerr++; $display("FAIL md_c0: got busy=%b pc=%b want 0 1", md_busy, pc_write); end
        cyc(); id_is_muldiv = 0; id_uses_hilo = 1; #1;  // cycle 1: mfhi
        nvec++; if (md_busy !== 1'b1 || md_done !== 1'b0 || pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin nerr++; $display("FAIL md_c1: got busy=%b done=%b pc=%b bub=%b want 1 0 0 1", md_busy, md_done, pc_write, id_ex_bubble); end
        cyc(); #1;  // cycle 2: mfhi
        nvec++; if (md_busy !== 1'b1 || md_done !== 1'b0 || pc_write !== 1'b0) begin nerr++; $display("FAIL md_c2: got busy=%b done=%b pc=%b want 1 0 0", md_busy, md_done, pc_write); end
        cyc(); id_uses_hilo = 0; #1;  // cycle 3: unrelated add
        nvec++; if (md_busy !== 1'b1 || md_done !== 1'b0 || pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin nerr++; $display("FAIL md_c3: got busy=%b done=%b pc=%b bub=%b want 1 0 1 0", md_busy, md_done, pc_write, id_ex_bubble); end
        cyc(); #1;  // cycle 4
        nvec++; if (md_busy !== 1'b1 || md_done !== 1'b1) begin nerr++; $display("FAIL md_c4: got busy=%b done=%b want 1 1", md_busy, md_done); end
        cyc(); #1;  // cycle 5
        nvec++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin nerr++; $display("FAIL md_c5: got busy=%b done=%b want 0 0", md_busy, md_done); end
    endtask

    task automatic test_reset_mid();
        cyc(); clr_inputs(); id_is_muldiv = 1;   // issue -> md_cnt 4
        cyc(); clr_inputs();                     // md_cnt 4
        cyc(); br_taken = 1; #1;                 // md_cnt 3, branch
        nvec++; if (md_busy !== 1'b1 || if_flush !== 1'b1) begin nerr++; $display("FAIL mid_br: got busy=%b if=%b want 1 1", md_busy, if_flush); end
        cyc(); br_taken = 0; #1;                 // md_cnt 2, FLUSH
        nvec++; if (md_busy !== 1'b1 || if_flush !== 1'b1) begin nerr++; $display("FAIL mid_fl: got busy=%b if=%b want 1 1", md_busy, if_flush); end
        rst = 0; #1;
        nvec++; if (md_busy !== 1'b0 || if_flush !== 1'b0 || pc_write !== 1'b0) begin nerr++; $display("FAIL mid_rst: got busy=%b if=%b pc=%b want 0 0 0", md_busy, if_flush, pc_write); end
        cyc(); rst = 1; #1;
        nvec++; if (md_busy !== 1'b0 || md_done !== 1'b0 || if_flush !== 1'b0 || pc_write !== 1'b1) begin nerr++; $display("FAIL mid_rel: got busy=%b done=%b if=%b pc=%b want 0 0 0 1", md_busy, md_done, if_flush, pc_write); end
        cyc(); #1;
        nvec++; if (md_done !== 1'b0 || if_flush !== 1'b0) begin nerr++; $display("FAIL mid_after: got done=%b if=%b want 0 0", md_done, if_flush); end
        cyc(); #1;
        nvec++; if (md_done !== 1'b0) begin nerr++; $display("FAIL mid_after2: got done=%b want 0", md_done); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_muldiv();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
